// File: rtl/file_mem_arbiter.sv
// Shares one single-port file memory among NUM_REQ requesters with a 2-cycle issue/response pipeline.
// Build option: define FILE_MEM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module file_mem_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_BITS  = 32,
    parameter int DATA_BYTES = 8
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*ADDR_BITS-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_BYTES*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]              req_r_wb,
    output logic [NUM_REQ-1:0]              resp_valid,
    output logic [DATA_BYTES*8-1:0]         resp_data,
    output logic                            mem_req_valid,
    output logic [ADDR_BITS-1:0]            mem_req_addr,
    output logic [DATA_BYTES*8-1:0]         mem_req_data,
    output logic                            mem_req_r_wb,
    input  logic [DATA_BYTES*8-1:0]         mem_resp_data,
    output logic                            busy
);
    localparam int DATA_BITS = DATA_BYTES * 8;
    localparam int IDX_BITS  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef logic [IDX_BITS-1:0] idx_t;
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t state, state_next;
    idx_t   owner, winner;
    logic   grant;

    logic [ADDR_BITS-1:0] addr_arr [NUM_REQ];
    logic [DATA_BITS-1:0] data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = req_addr[g*ADDR_BITS +: ADDR_BITS];
        assign data_arr[g] = req_data[g*DATA_BITS +: DATA_BITS];
    end

    // A grant is offered whenever the memory port is not mid-strobe, including the RESP cycle.
    assign grant = reset_n && (state != ISSUE) && (|req_valid);

`ifdef FILE_MEM_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[idx_t'(i)]) winner = idx_t'(i);
        end
    end
`else
    idx_t rr_ptr;

    always_comb begin : rr_scan
        logic found;
        int   idx;
        // NOTE: every variable assigned in always_comb gets a default first, so no path leaves a latch.
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!found && req_valid[idx_t'(idx)]) begin
                winner = idx_t'(idx);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n)   rr_ptr <= idx_t'(NUM_REQ - 1);
        else if (grant) rr_ptr <= winner;
    end
`endif

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (grant) state_next = ISSUE;
            ISSUE:   state_next = RESP;
            RESP:    state_next = grant ? ISSUE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            state         <= IDLE;
            owner         <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_data  <= '0;
            mem_req_r_wb  <= 1'b0;
        end else begin
            state         <= state_next;
            mem_req_valid <= grant;
            if (grant) begin
                owner        <= winner;
                mem_req_addr <= addr_arr[winner];
                mem_req_data <= data_arr[winner];
                mem_req_r_wb <= req_r_wb[winner];
            end
        end
    end

    assign req_ready  = grant ? (NUM_REQ'(1) << winner) : '0;
    assign resp_valid = (state == RESP) ? (NUM_REQ'(1) << owner) : '0;
    // mem_req_r_wb still describes the owner's access during RESP; a new grant only replaces it at the edge.
    assign resp_data  = ((state == RESP) && mem_req_r_wb) ? mem_resp_data : '0;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_file_mem_arbiter.sv
// Self-checking bench for file_mem_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level schedule model.
module tb_file_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = $clog2(N);

    logic            clock = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_valid, req_ready, req_r_wb, resp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [DW-1:0]   resp_data, mem_req_data;
    logic [DW-1:0]   mem_resp_data = '0;
    logic [AW-1:0]   mem_req_addr;
    logic            mem_req_valid, mem_req_r_wb, busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    file_mem_arbiter #(.NUM_REQ(N), .ADDR_BITS(AW), .DATA_BYTES(DW/8)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_data(req_data), .req_r_wb(req_r_wb),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_r_wb(mem_req_r_wb),
        .mem_resp_data(mem_resp_data), .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Unwritten locations read back as a fixed pattern derived from the address.
    function automatic logic [DW-1:0] fill(input logic [AW-1:0] a);
        return {~a, a ^ 32'h5A5A_C3C3};
    endfunction

    // Behavioural memory: samples on the strobe edge, read data appears the following cycle.
    logic [DW-1:0] mem_store [logic [AW-1:0]];
    always @(posedge clock) begin
        if (mem_req_valid) begin
            if (mem_req_r_wb)
                mem_resp_data <= mem_store.exists(mem_req_addr) ? mem_store[mem_req_addr] : fill(mem_req_addr);
            else
                mem_store[mem_req_addr] = mem_req_data;
        end
    end

    // ---------------- reference model: a schedule of accesses, not an FSM ----------------
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    int            cyc        = 0;
    int            next_ok    = 0;
    int            strobe_cyc = -10;
    int            resp_cyc   = -10;
    int            last_win   = N - 1;
    int            own        = 0;
    logic          own_read   = 1'b0;
    logic [DW-1:0] own_data   = '0;
    logic [AW-1:0] m_addr     = '0;
    logic [DW-1:0] m_data     = '0;
    logic          m_rwb      = 1'b0;
    logic          pend_rst   = 1'b1;
    logic          pend_grant = 1'b0;
    int            pend_win   = 0;
    logic [N-1:0]  granted_mask = '0;
    logic          e_grant;
    int            e_win;
    logic [N-1:0]  e_ready, e_rv;

    function automatic int pick(input logic [N-1:0] v, input int last);
`ifdef FILE_MEM_ARB_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) if (v[IW'(k)]) return k;
        return last - last;
`else
        for (int k = 1; k <= N; k++) if (v[IW'((last + k) % N)]) return (last + k) % N;
        return 0;
`endif
    endfunction

    always @(negedge clock) begin
        if (cyc > 0) begin
            e_grant = reset_n && (cyc >= next_ok) && (|req_valid);
            e_win   = pick(req_valid, last_win);
            e_ready = e_grant ? (N'(1) << e_win) : '0;
            e_rv    = (cyc == resp_cyc) ? (N'(1) << own) : '0;
            check("req_ready", req_ready, e_ready);
            check("mem_req_valid", mem_req_valid, (cyc == strobe_cyc));
            check("mem_req_addr", mem_req_addr, m_addr);
            check("mem_req_data", mem_req_data, m_data);
            check("mem_req_r_wb", mem_req_r_wb, m_rwb);
            check("resp_valid", resp_valid, e_rv);
            check("busy", busy, (cyc == strobe_cyc) || (cyc == resp_cyc));
            if (cyc == resp_cyc) check("resp_data", resp_data, own_read ? own_data : '0);
            pend_grant = e_grant;
            pend_win   = e_win;
            pend_rst   = !reset_n;
        end
    end

    always @(posedge clock) begin
        granted_mask = '0;
        if (pend_rst) begin
            last_win = N - 1; next_ok = 0; strobe_cyc = -10; resp_cyc = -10;
            m_addr = '0; m_data = '0; m_rwb = 1'b0;
        end else if (pend_grant) begin
            granted_mask = N'(1) << pend_win;
            last_win = pend_win;
            own      = pend_win;
            m_addr   = req_addr[pend_win*AW +: AW];
            m_data   = req_data[pend_win*DW +: DW];
            m_rwb    = req_r_wb[pend_win];
            own_read = m_rwb;
            if (m_rwb) begin
                own_data = ref_mem.exists(m_addr) ? ref_mem[m_addr] : fill(m_addr);
            end else begin
                ref_mem[m_addr] = m_data;
                own_data = '0;
            end
            strobe_cyc = cyc + 1;
            resp_cyc   = cyc + 2;
            next_ok    = cyc + 2;
        end
        pend_grant = 1'b0;
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset_n   = 1'b0;
        req_valid = '0;
        step();
        reset_n   = 1'b1;
    endtask

    task automatic set_req(input int i, input logic rwb, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = 1'b1;
        req_r_wb[i]           = rwb;
        req_addr[i*AW +: AW]  = a;
        req_data[i*DW +: DW]  = d;
    endtask

    task automatic random_phase(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < N; i++) begin
                if (granted_mask[i] || !req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0)
                        set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7) * 8),
                                {$urandom, $urandom});
                    else
                        req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] exp_mask;
        reset_n   = 1'b0;
        req_valid = '1;
        req_r_wb  = '1;
        req_addr  = '0;
        req_data  = '0;

        // 1. Reset with every requester asking.
        repeat (3) begin
            @(posedge clock);
            @(negedge clock);
            check("rst req_ready", req_ready, 0);
            check("rst mem_req_valid", mem_req_valid, 0);
            check("rst resp_valid", resp_valid, 0);
            check("rst busy", busy, 0);
        end
        step();
        reset_n   = 1'b1;
        req_valid = '0;

        // 2. Single read from requester 0.
        mem_store[32'h40] = 64'hDEAD_BEEF;
        ref_mem[32'h40]   = 64'hDEAD_BEEF;
        set_req(0, 1'b1, 32'h40, '0);
        @(negedge clock);
        check("t2 ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        @(negedge clock);
        check("t2 mem_valid", mem_req_valid, 1);
        check("t2 mem_addr", mem_req_addr, 32'h40);
        check("t2 mem_rwb", mem_req_r_wb, 1);
        step();
        @(negedge clock);
        check("t2 resp_valid", resp_valid, 4'b0001);
        check("t2 resp_data", resp_data, 64'hDEAD_BEEF);
        step();

        // 3. Write then read from requester 2, second grant taken in the RESP cycle.
        set_req(2, 1'b0, 32'h80, 64'h1234);
        @(negedge clock);
        check("t3 wr ready", req_ready, 4'b0100);
        step();
        req_r_wb[2] = 1'b1;
        @(negedge clock);
        check("t3 wr strobe", mem_req_valid, 1);
        check("t3 wr rwb", mem_req_r_wb, 0);
        check("t3 wr addr", mem_req_addr, 32'h80);
        check("t3 wr data", mem_req_data, 64'h1234);
        step();
        @(negedge clock);
        check("t3 wr ack", resp_valid, 4'b0100);
        check("t3 wr ack data", resp_data, 0);
        check("t3 rd ready", req_ready, 4'b0100);
        step();
        req_valid = '0;
        @(negedge clock);
        check("t3 rd strobe", mem_req_valid, 1);
        check("t3 rd rwb", mem_req_r_wb, 1);
        step();
        @(negedge clock);
        check("t3 rd resp", resp_valid, 4'b0100);
        check("t3 rd data", resp_data, 64'h1234);
        step();

        // 4. Full contention after reset.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i * 8), '0);
        for (int k = 0; k < 5; k++) begin
`ifdef FILE_MEM_ARB_FIXED_PRIO_EN
            exp_mask = 4'b0001;
`else
            exp_mask = N'(1) << (k % N);
`endif
            @(negedge clock);
            check("t4 grant", req_ready, exp_mask);
            step();
            @(negedge clock);
            check("t4 issue no ready", req_ready, 0);
            step();
        end
        req_valid = '0;

        // 5. Sole requester 3: pointer wraps and it wins back-to-back.
        do_reset();
        set_req(3, 1'b1, 32'h10, '0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("t5 ready", req_ready, 4'b1000);
            if (k > 0) check("t5 resp", resp_valid, 4'b1000);
            step();
            if (k == 2) req_valid = '0;
            @(negedge clock);
            check("t5 strobe", mem_req_valid, 1);
            step();
        end
        @(negedge clock);
        check("t5 last resp", resp_valid, 4'b1000);
        check("t5 idle ready", req_ready, 0);
        step();

        // 6. Reset during ISSUE drops the response and restarts arbitration at requester 0.
        do_reset();
        set_req(0, 1'b1, 32'h20, '0);
        @(negedge clock);
        check("t6 ready", req_ready, 4'b0001);
        step();
        reset_n = 1'b0;
        set_req(1, 1'b1, 32'h28, '0);
        @(negedge clock);
        check("t6 strobe in flight", mem_req_valid, 1);
        step();
        reset_n = 1'b1;
        @(negedge clock);
        check("t6 no resp", resp_valid, 0);
        check("t6 regrant", req_ready, 4'b0001);
        step();

        // Randomized traffic checked by the model every cycle.
        random_phase(600);
        req_valid = '0;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
